// File: rtl/acl_cmd_responder.sv
// ADXL362 command responder: turns tester command levels into ordered
// register-write requests toward the SPI layer and tracks sensor mode.
module acl_cmd_responder #(
    parameter int unsigned c_reset_wait_cycles = 10000
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rstn_20mhz,
    input  logic       i_cmd_init_measur,
    input  logic       i_cmd_start_measur,
    input  logic       i_cmd_init_linked,
    input  logic       i_cmd_start_linked,
    input  logic       i_cmd_soft_reset,
    output logic       o_command_ready,
    output logic       o_reg_wr_valid,
    output logic [7:0] o_reg_wr_addr,
    output logic [7:0] o_reg_wr_data,
    input  logic       i_reg_wr_ready,
    input  logic       i_reg_wr_done,
    output logic       o_mode_measur_active,
    output logic       o_mode_linked_active,
    output logic       o_cmd_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_SETTLE,
        ST_RELEASE
    } state_t;

    typedef enum logic [2:0] {
        CMD_SOFT_RESET,
        CMD_INIT_MEASUR,
        CMD_START_MEASUR,
        CMD_INIT_LINKED,
        CMD_START_LINKED
    } cmd_t;

    // Counter holds the full wait value so it can never wrap.
    localparam int unsigned CNT_W =
        (c_reset_wait_cycles < 2) ? 1 : $clog2(c_reset_wait_cycles + 1);
    localparam int unsigned SETTLE_LAST_I =
        (c_reset_wait_cycles == 0) ? 0 : c_reset_wait_cycles - 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = SETTLE_LAST_I[CNT_W-1:0];

    // Write table: {addr, data} for each step of each command.
    function automatic logic [15:0] seq_entry(
        input cmd_t       cmd,
        input logic [2:0] idx
    );
        logic [15:0] e;
        e = 16'h0000;
        case (cmd)
            CMD_SOFT_RESET:   e = 16'h1F52;
            CMD_INIT_MEASUR:  e = 16'h2C13;
            CMD_START_MEASUR: e = 16'h2D02;
            CMD_START_LINKED: e = 16'h2D0A;
            CMD_INIT_LINKED: begin
                case (idx)
                    3'd0:    e = 16'h20FA;
                    3'd1:    e = 16'h2100;
                    3'd2:    e = 16'h2396;
                    3'd3:    e = 16'h2400;
                    3'd4:    e = 16'h251E;
                    3'd5:    e = 16'h273F;
                    default: e = 16'h0000;
                endcase
            end
            default: e = 16'h0000;
        endcase
        return e;
    endfunction

    // Index of the final write of a command's sequence.
    function automatic logic [2:0] seq_last(input cmd_t cmd);
        return (cmd == CMD_INIT_LINKED) ? 3'd5 : 3'd0;
    endfunction

    state_t           state, state_n;
    cmd_t             cmd, cmd_n;
    logic [2:0]       idx, idx_n;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_n;
    logic             abort_pend, abort_pend_n;
    logic             rst_serviced, rst_serviced_n;
    logic             armed_measur, armed_measur_n;
    logic             armed_linked, armed_linked_n;
    logic             mode_measur, mode_measur_n;
    logic             mode_linked, mode_linked_n;
    logic             cmd_error, cmd_error_n;

    logic             sr_req;
    logic             sr_abort;
    logic             any_cmd;
    logic             handshake;
    logic [15:0]      entry;

    // A soft reset counts only until it has been taken once at this level.
    assign sr_req    = i_cmd_soft_reset && !rst_serviced;
    assign sr_abort  = sr_req && (cmd != CMD_SOFT_RESET);
    assign any_cmd   = i_cmd_init_measur | i_cmd_start_measur |
                       i_cmd_init_linked | i_cmd_start_linked |
                       i_cmd_soft_reset;
    assign entry     = seq_entry(cmd, idx);

    assign o_command_ready      = (state == ST_IDLE);
    assign o_reg_wr_valid       = (state == ST_ISSUE) && !sr_abort;
    assign o_reg_wr_addr        = (state == ST_ISSUE) ? entry[15:8] : 8'h00;
    assign o_reg_wr_data        = (state == ST_ISSUE) ? entry[7:0] : 8'h00;
    assign o_mode_measur_active = mode_measur;
    assign o_mode_linked_active = mode_linked;
    assign o_cmd_error          = cmd_error;
    assign handshake            = o_reg_wr_valid && i_reg_wr_ready;

    // State and bookkeeping registers.
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state        <= ST_IDLE;
            cmd          <= CMD_SOFT_RESET;
            idx          <= 3'd0;
            settle_cnt   <= '0;
            abort_pend   <= 1'b0;
            rst_serviced <= 1'b0;
            armed_measur <= 1'b0;
            armed_linked <= 1'b0;
            mode_measur  <= 1'b0;
            mode_linked  <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            state        <= state_n;
            cmd          <= cmd_n;
            idx          <= idx_n;
            settle_cnt   <= settle_cnt_n;
            abort_pend   <= abort_pend_n;
            rst_serviced <= rst_serviced_n;
            armed_measur <= armed_measur_n;
            armed_linked <= armed_linked_n;
            mode_measur  <= mode_measur_n;
            mode_linked  <= mode_linked_n;
            cmd_error    <= cmd_error_n;
        end
    end

    // Next-state, command capture, sequencing and completion effects.
    always_comb begin
        state_n        = state;
        cmd_n          = cmd;
        idx_n          = idx;
        settle_cnt_n   = settle_cnt;
        abort_pend_n   = abort_pend;
        rst_serviced_n = rst_serviced;
        armed_measur_n = armed_measur;
        armed_linked_n = armed_linked;
        mode_measur_n  = mode_measur;
        mode_linked_n  = mode_linked;
        cmd_error_n    = 1'b0;

        if (!i_cmd_soft_reset) begin
            rst_serviced_n = 1'b0;
        end

        unique case (state)
            ST_IDLE: begin
                abort_pend_n = 1'b0;
                idx_n        = 3'd0;
                if (sr_req) begin
                    cmd_n          = CMD_SOFT_RESET;
                    rst_serviced_n = 1'b1;
                    state_n        = ST_ISSUE;
                end else if (i_cmd_init_measur) begin
                    cmd_n   = CMD_INIT_MEASUR;
                    state_n = ST_ISSUE;
                end else if (i_cmd_start_measur) begin
                    if (armed_measur) begin
                        cmd_n   = CMD_START_MEASUR;
                        state_n = ST_ISSUE;
                    end else begin
                        cmd_error_n = 1'b1;
                        state_n     = ST_RELEASE;
                    end
                end else if (i_cmd_init_linked) begin
                    cmd_n   = CMD_INIT_LINKED;
                    state_n = ST_ISSUE;
                end else if (i_cmd_start_linked) begin
                    if (armed_linked) begin
                        cmd_n   = CMD_START_LINKED;
                        state_n = ST_ISSUE;
                    end else begin
                        cmd_error_n = 1'b1;
                        state_n     = ST_RELEASE;
                    end
                end
            end

            ST_ISSUE: begin
                if (sr_abort) begin
                    // Nothing in flight yet: switch straight to the reset write.
                    cmd_n          = CMD_SOFT_RESET;
                    idx_n          = 3'd0;
                    abort_pend_n   = 1'b0;
                    rst_serviced_n = 1'b1;
                end else if (handshake) begin
                    state_n = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (sr_abort) begin
                    abort_pend_n   = 1'b1;
                    rst_serviced_n = 1'b1;
                end
                if (i_reg_wr_done) begin
                    if (abort_pend_n) begin
                        cmd_n        = CMD_SOFT_RESET;
                        idx_n        = 3'd0;
                        abort_pend_n = 1'b0;
                        state_n      = ST_ISSUE;
                    end else if (idx != seq_last(cmd)) begin
                        idx_n   = idx + 3'd1;
                        state_n = ST_ISSUE;
                    end else begin
                        settle_cnt_n = '0;
                        state_n      = ST_RELEASE;
                        case (cmd)
                            CMD_SOFT_RESET: begin
                                armed_measur_n = 1'b0;
                                armed_linked_n = 1'b0;
                                mode_measur_n  = 1'b0;
                                mode_linked_n  = 1'b0;
                                state_n        = ST_SETTLE;
                            end
                            CMD_INIT_MEASUR: begin
                                armed_measur_n = 1'b1;
                                armed_linked_n = 1'b0;
                                mode_measur_n  = 1'b0;
                                mode_linked_n  = 1'b0;
                            end
                            CMD_INIT_LINKED: begin
                                armed_linked_n = 1'b1;
                                armed_measur_n = 1'b0;
                                mode_measur_n  = 1'b0;
                                mode_linked_n  = 1'b0;
                            end
                            CMD_START_MEASUR: begin
                                mode_measur_n = 1'b1;
                                mode_linked_n = 1'b0;
                            end
                            CMD_START_LINKED: begin
                                mode_linked_n = 1'b1;
                                mode_measur_n = 1'b0;
                            end
                            default: begin
                                state_n = ST_RELEASE;
                            end
                        endcase
                    end
                end
            end

            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_n = '0;
                    state_n      = ST_IDLE;
                end else begin
                    settle_cnt_n = settle_cnt + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (!any_cmd) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/acl_cmd_responder.md
ACL_CMD_RESPONDER -- requirements
Module: acl_cmd_responder

Interface
REQ-001 SHALL have parameter c_reset_wait_cycles, default 10000, the post-soft-reset settle time in clocks (0.5 ms at 20 MHz).
REQ-002 SHALL have port i_clk_20mhz  input  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port i_rstn_20mhz  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports i_cmd_init_measur, i_cmd_start_measur, i_cmd_init_linked, i_cmd_start_linked  input  1 each  level command requests from the tester FSM.
REQ-005 SHALL have port i_cmd_soft_reset  input  1  level soft-reset request; may be held high across completion.
REQ-006 SHALL have port o_command_ready  output  1  high when idle and able to accept a command.
REQ-007 SHALL have ports o_reg_wr_valid  output  1, o_reg_wr_addr  output  8, o_reg_wr_data  output  8  register-write request to the SPI layer.
REQ-008 SHALL have port i_reg_wr_ready  input  1  the SPI layer accepts the request on a cycle where valid and ready are both high.
REQ-009 SHALL have port i_reg_wr_done  input  1  one-cycle pulse when the accepted SPI write has finished on the bus.
REQ-010 SHALL have ports o_mode_measur_active, o_mode_linked_active  output  1 each  the ADXL362 is running in that mode.
REQ-011 SHALL have port o_cmd_error  output  1  one-cycle pulse when a start command has no matching init.

Function
REQ-012 SHALL use these states: IDLE, ISSUE, WAIT_DONE, SETTLE, RELEASE.
REQ-013 In IDLE, o_command_ready SHALL be 1; in every other state it SHALL be 0.
REQ-014 A command SHALL be accepted in IDLE on cycle N when its input is high; at N+1, ready=0, state=ISSUE, and valid=1 carrying the first write of the sequence.
REQ-015 Simultaneous requests SHALL be resolved by priority, highest first: soft_reset > init_measur > start_measur > init_linked > start_linked; lower-priority requests are ignored.
REQ-016 Write sequences SHALL be {addr, data}:
- soft_reset: {1F,52}
- init_measur: {2C,13}
- start_measur: {2D,02}
- init_linked: {20,FA}, {21,00}, {23,96}, {24,00}, {25,1E}, {27,3F}
- start_linked: {2D,0A}
REQ-017 In ISSUE, valid, addr and data SHALL be held stable until the handshake; on the handshake cycle the FSM goes to WAIT_DONE and valid drops the next cycle.
REQ-018 In WAIT_DONE, on i_reg_wr_done: if more entries remain, go to ISSUE with the next entry (index increments by 1); otherwise go to SETTLE for soft_reset, or RELEASE for all other commands.
REQ-019 SETTLE SHALL count c_reset_wait_cycles clocks, then go to IDLE.
REQ-020 RELEASE SHALL go to IDLE on the first cycle where all five command inputs are low, so a held level does not retrigger.
REQ-021 A soft_reset held high after returning to IDLE SHALL NOT retrigger; a serviced flag SHALL block it until the input goes low.
REQ-022 A soft_reset rising during ISSUE or WAIT_DONE SHALL abort the current sequence after the outstanding write completes; the FSM then issues {1F,52} without returning to IDLE.
REQ-022a A soft_reset rising during ISSUE before the handshake SHALL drop valid immediately.
REQ-023 Soft-reset completion SHALL clear the armed flags and both mode outputs.
REQ-024 init_measur completion SHALL set armed_measur and clear armed_linked and both mode outputs; init_linked completion SHALL do the mirror.
REQ-025 start_measur with armed_measur=0, or start_linked with armed_linked=0, SHALL pulse o_cmd_error at N+1, issue no write, and go straight to RELEASE.
REQ-026 A successful start SHALL set its mode output and clear the other mode output at completion.
REQ-027 i_reg_wr_done outside WAIT_DONE SHALL be ignored; i_reg_wr_ready outside ISSUE SHALL be ignored.
REQ-028 The settle counter SHALL be wide enough for c_reset_wait_cycles and SHALL never wrap.

Reset
REQ-029 While i_rstn_20mhz=0, the block SHALL asynchronously force: state=IDLE, o_command_ready=1, o_reg_wr_valid=0, addr=00, data=00, both mode outputs=0, o_cmd_error=0, armed and serviced flags=0, counters=0.
REQ-030 Reset mid-sequence SHALL abandon the sequence with no further write; the first clock after release SHALL be in IDLE.

Verification
REQ-031 Measurement flow (spi ready=1, done 3 clocks after accept): init_measur high -> ready=0 next clock, one write {2C,13}; release command -> ready=1. Then start_measur -> {2D,02}; o_mode_measur_active=1.
REQ-032 Linked init: exactly six writes appear in the table order; ready returns only after the 6th done and with the command low; o_mode_linked_active stays 0 until start_linked.
REQ-033 Error path: start_linked from reset -> o_cmd_error one clock, zero valid cycles, mode outputs 0.
REQ-034 Soft-reset abort: soft_reset rises during the 3rd init_linked write -> that write completes, then {1F,52}, settle of c_reset_wait_cycles=16 clocks, ready=1 while soft_reset still high, no second {1F,52}; all mode outputs 0.
REQ-035 Priority and backpressure: init_measur and start_linked high together, i_reg_wr_ready low for 5 clocks -> only {2C,13} is issued, held stable all 5 clocks.
REQ-036 Async reset asserted in WAIT_DONE -> outputs take reset values immediately, with no clock edge required.
